// File: rtl/exec_ctrl_seq.sv
// exec_ctrl_seq
// Sequential execute-stage controller for the multicycle processor. Takes one
// opcode per valid/ready handshake from decode, drives the ALU operand/op
// selects, memory strobes and write enables, waits on memory with a timeout,
// then hands the retired instruction to writeback. Supports squash (flush)
// and a sticky halt.
//
// Ports
//   clock, resetn        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    decode handshake (in_ready only in IDLE)
//   instr                opcode
//   flush                squash the current instruction
//   mem_ack              memory completes the access this cycle
//   out_ready/out_valid  writeback handshake
//   mem_read/mem_write   load/store request, held through MEM
//   mdr_load             capture read data on the load ack cycle
//   flag_write           flag update, ALU ops, EXEC cycle
//   alu_out_write        ALU result write, ALU ops, EXEC cycle
//   ir3_load             handoff pulse to IR3
//   alu1, alu_2, alu_op  ALU A mux, B mux and operation
//   halted, mem_err      sticky status flags
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an opcode; in_ready high
// EXEC  | single ALU/branch cycle; write enables for ALU ops
// MEM   | load/store strobe held until mem_ack or timeout
// HAND  | out_valid high until writeback takes it
// HALT  | stop executed; sticky until resetn

module exec_ctrl_seq #(
    parameter int OPW         = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CW          = 4
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] instr,
    input  logic           flush,
    input  logic           mem_ack,
    input  logic           out_ready,
    output logic           out_valid,
    output logic           mem_read,
    output logic           mem_write,
    output logic           mdr_load,
    output logic           flag_write,
    output logic           alu_out_write,
    output logic           ir3_load,
    output logic [1:0]     alu1,
    output logic [2:0]     alu_2,
    output logic [2:0]     alu_op,
    output logic           halted,
    output logic           mem_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MEM,
        S_HAND,
        S_HALT
    } state_t;

    // Decoded view of an opcode; latched at acceptance so later states only
    // need to look at the stored selects.
    typedef struct packed {
        logic       ld;
        logic       st;
        logic       alu;
        logic [1:0] a1;
        logic [2:0] a2;
        logic [2:0] op;
    } dec_t;

    localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

    function automatic dec_t decode(input logic [OPW-1:0] o);
        dec_t       d;
        logic [3:0] lo;
        d    = '0;
        d.a1 = 2'b01;
        lo   = o[3:0];
        // Any set bit above [3:0] makes the opcode unknown: default selects.
        if ((o >> 4) == '0) begin
            if (lo[2:0] == 3'd3) begin
                d.a2  = 3'b100;
                d.op  = 3'b100;
                d.alu = 1'b1;
            end else if (lo[2:0] == 3'd7) begin
                d.a2  = 3'b011;
                d.op  = 3'b010;
                d.alu = 1'b1;
            end else begin
                case (lo)
                    4'd4: d.alu = 1'b1;
                    4'd6: begin
                        d.op  = 3'b001;
                        d.alu = 1'b1;
                    end
                    4'd8: begin
                        d.op  = 3'b011;
                        d.alu = 1'b1;
                    end
                    4'd0: begin
                        d.ld = 1'b1;
                        d.op = 3'b010;
                    end
                    4'd2: begin
                        d.st = 1'b1;
                        d.op = 3'b010;
                    end
                    4'd10, 4'd5, 4'd9, 4'd13: begin
                        d.a1 = 2'b00;
                        d.a2 = 3'b010;
                    end
                    default: ;
                endcase
            end
        end
        return d;
    endfunction

    state_t        state, state_nxt;
    dec_t          dec_q, dec_nxt, dec_in;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          flush_pend, fp_nxt;
    logic          err_nxt;
    logic          squash;
    logic          stop_in;

    assign dec_in  = decode(instr);
    assign stop_in = (instr == OPW'(1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            dec_q      <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            dec_q      <= dec_nxt;
            cnt        <= cnt_nxt;
            flush_pend <= fp_nxt;
            mem_err    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        dec_nxt       = dec_q;
        cnt_nxt       = cnt;
        fp_nxt        = flush_pend;
        err_nxt       = mem_err;
        squash        = 1'b0;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mdr_load      = 1'b0;
        flag_write    = 1'b0;
        alu_out_write = 1'b0;
        ir3_load      = 1'b0;
        halted        = 1'b0;
        alu1          = 2'b01;
        alu_2         = 3'b000;
        alu_op        = 3'b000;

        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                // A flush in the acceptance cycle squashes the incoming opcode.
                if (in_valid && !flush) begin
                    dec_nxt = dec_in;
                    if (stop_in) begin
                        state_nxt = S_HALT;
                    end else if (dec_in.ld || dec_in.st) begin
                        state_nxt = S_MEM;
                        cnt_nxt   = '0;
                        fp_nxt    = 1'b0;
                    end else begin
                        state_nxt = S_EXEC;
                    end
                end
            end

            S_EXEC: begin
                alu1   = dec_q.a1;
                alu_2  = dec_q.a2;
                alu_op = dec_q.op;
                if (flush) begin
                    state_nxt = S_IDLE;
                end else begin
                    alu_out_write = dec_q.alu;
                    flag_write    = dec_q.alu;
                    state_nxt     = S_HAND;
                end
            end

            S_MEM: begin
                alu1      = dec_q.a1;
                alu_2     = dec_q.a2;
                alu_op    = dec_q.op;
                mem_read  = dec_q.ld;
                mem_write = dec_q.st;
                // The access always runs to completion; a flush only decides
                // whether the result is handed on afterwards.
                squash    = flush_pend | flush;
                if (mem_ack) begin
                    mdr_load  = dec_q.ld;
                    state_nxt = squash ? S_IDLE : S_HAND;
                    fp_nxt    = 1'b0;
                end else if (cnt == TMO_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = squash ? S_IDLE : S_HAND;
                    fp_nxt    = 1'b0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                    fp_nxt  = squash;
                end
            end

            S_HAND: begin
                alu1      = dec_q.a1;
                alu_2     = dec_q.a2;
                alu_op    = dec_q.op;
                out_valid = 1'b1;
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (out_ready) begin
                    ir3_load  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_exec_ctrl_seq.sv
module tb_exec_ctrl_seq;

    localparam int OPW         = 4;
    localparam int MEM_TIMEOUT = 15;
    localparam int CW          = 4;

    logic           clock     = 1'b0;
    logic           resetn    = 1'b0;
    logic           in_valid  = 1'b0;
    logic           flush     = 1'b0;
    logic           mem_ack   = 1'b0;
    logic           out_ready = 1'b0;
    logic [OPW-1:0] instr     = '0;
    logic           in_ready, out_valid, mem_read, mem_write, mdr_load;
    logic           flag_write, alu_out_write, ir3_load, halted, mem_err;
    logic [1:0]     alu1;
    logic [2:0]     alu_2, alu_op;

    int errors = 0;
    int checks = 0;

    exec_ctrl_seq #(
        .OPW(OPW),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CW(CW)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .instr(instr),
        .flush(flush),
        .mem_ack(mem_ack),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mdr_load(mdr_load),
        .flag_write(flag_write),
        .alu_out_write(alu_out_write),
        .ir3_load(ir3_load),
        .alu1(alu1),
        .alu_2(alu_2),
        .alu_op(alu_op),
        .halted(halted),
        .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] a1;
        logic [2:0] a2;
        logic [2:0] aop;
        logic       we;
    } vec_t;

    vec_t vecs[13];
    vec_t sb[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Returns 1 ns after the next rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t e;
        int   n;

        vecs[0]  = '{4'd4,  2'b01, 3'b000, 3'b000, 1'b1};  // add
        vecs[1]  = '{4'd6,  2'b01, 3'b000, 3'b001, 1'b1};  // sub
        vecs[2]  = '{4'd8,  2'b01, 3'b000, 3'b011, 1'b1};  // nand
        vecs[3]  = '{4'd3,  2'b01, 3'b100, 3'b100, 1'b1};  // shift
        vecs[4]  = '{4'd11, 2'b01, 3'b100, 3'b100, 1'b1};  // shift
        vecs[5]  = '{4'd7,  2'b01, 3'b011, 3'b010, 1'b1};  // ori
        vecs[6]  = '{4'd15, 2'b01, 3'b011, 3'b010, 1'b1};  // ori
        vecs[7]  = '{4'd10, 2'b00, 3'b010, 3'b000, 1'b0};  // nop
        vecs[8]  = '{4'd5,  2'b00, 3'b010, 3'b000, 1'b0};  // bz
        vecs[9]  = '{4'd9,  2'b00, 3'b010, 3'b000, 1'b0};  // bnz
        vecs[10] = '{4'd13, 2'b00, 3'b010, 3'b000, 1'b0};  // bpz
        vecs[11] = '{4'd12, 2'b01, 3'b000, 3'b000, 1'b0};  // unknown
        vecs[12] = '{4'd14, 2'b01, 3'b000, 3'b000, 1'b0};  // unknown

        // Reset state
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_halted", halted, 0);
        chk("rst_mem_err", mem_err, 0);
        chk("rst_alu1", alu1, 1);
        chk("rst_alu_2", alu_2, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_strobes", {mem_read, mem_write, mdr_load, flag_write, alu_out_write, ir3_load}, 0);
        cyc();
        cyc();
        resetn = 1'b1;

        // Table-driven ALU/branch/unknown opcodes through EXEC and HAND
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            instr    = vecs[i].op;
            #1;
            chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            sb.push_back(vecs[i]);
            cyc();
            in_valid = 1'b0;
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_exec_alu1", i), alu1, e.a1);
            chk($sformatf("v%0d_exec_alu_2", i), alu_2, e.a2);
            chk($sformatf("v%0d_exec_alu_op", i), alu_op, e.aop);
            chk($sformatf("v%0d_exec_alu_out_write", i), alu_out_write, e.we);
            chk($sformatf("v%0d_exec_flag_write", i), flag_write, e.we);
            chk($sformatf("v%0d_exec_out_valid", i), out_valid, 0);
            chk($sformatf("v%0d_exec_in_ready", i), in_ready, 0);
            cyc();
            #1;
            chk($sformatf("v%0d_hand_out_valid", i), out_valid, 1);
            chk($sformatf("v%0d_hand_ir3_load", i), ir3_load, 1);
            chk($sformatf("v%0d_hand_alu_op", i), alu_op, e.aop);
            chk($sformatf("v%0d_hand_we", i), alu_out_write, 0);
            cyc();
            #1;
            chk($sformatf("v%0d_idle_in_ready", i), in_ready, 1);
        end

        // Load, ack on the 4th MEM cycle, then writeback stalls 5 cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 4'd0;
        cyc();
        in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            mem_ack = (c == 4);
            #1;
            chk($sformatf("ld_c%0d_mem_read", c), mem_read, 1);
            chk($sformatf("ld_c%0d_mdr_load", c), mdr_load, (c == 4) ? 1 : 0);
            chk($sformatf("ld_c%0d_alu_op", c), alu_op, 2);
            chk($sformatf("ld_c%0d_alu_2", c), alu_2, 0);
            cyc();
        end
        mem_ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("stall%0d_out_valid", c), out_valid, 1);
            chk($sformatf("stall%0d_ir3_load", c), ir3_load, 0);
            chk($sformatf("stall%0d_in_ready", c), in_ready, 0);
            chk($sformatf("stall%0d_mem_read", c), mem_read, 0);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        chk("ld_ir3_load", ir3_load, 1);
        cyc();
        #1;
        chk("ld_idle_in_ready", in_ready, 1);

        // Store with no ack: timeout after MEM_TIMEOUT cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 4'd2;
        cyc();
        in_valid = 1'b0;
        #1;
        n = 0;
        while (mem_write && n < 40) begin
            n++;
            cyc();
            #1;
        end
        chk("st_write_cycles", n, MEM_TIMEOUT);
        chk("st_write_dropped", mem_write, 0);
        chk("st_mem_err", mem_err, 1);
        chk("st_out_valid", out_valid, 1);
        out_ready = 1'b1;
        cyc();
        #1;
        chk("st_mem_err_sticky", mem_err, 1);
        chk("st_idle_in_ready", in_ready, 1);

        // Flush during MEM: access completes, HAND is skipped
        in_valid = 1'b1;
        instr    = 4'd0;
        cyc();
        in_valid = 1'b0;
        #1;
        cyc();
        flush = 1'b1;
        #1;
        chk("fl_mem_read_flush", mem_read, 1);
        cyc();
        flush = 1'b0;
        #1;
        chk("fl_mem_read_held", mem_read, 1);
        mem_ack = 1'b1;
        #1;
        chk("fl_mdr_load", mdr_load, 1);
        cyc();
        mem_ack = 1'b0;
        #1;
        chk("fl_no_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        chk("fl_mem_read_off", mem_read, 0);

        // Flush during EXEC: write enables suppressed, back to IDLE
        in_valid = 1'b1;
        instr    = 4'd4;
        cyc();
        in_valid = 1'b0;
        flush    = 1'b1;
        #1;
        chk("fe_alu_out_write", alu_out_write, 0);
        chk("fe_flag_write", flag_write, 0);
        cyc();
        flush = 1'b0;
        #1;
        chk("fe_out_valid", out_valid, 0);
        chk("fe_in_ready", in_ready, 1);

        // Stop: sticky halt, further opcodes ignored
        in_valid = 1'b1;
        instr    = 4'd1;
        cyc();
        instr = 4'd4;
        #1;
        chk("halt_halted", halted, 1);
        chk("halt_in_ready", in_ready, 0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            #1;
            chk($sformatf("halt%0d_halted", c), halted, 1);
            chk($sformatf("halt%0d_alu_out_write", c), alu_out_write, 0);
            chk($sformatf("halt%0d_ir3_load", c), ir3_load, 0);
        end
        in_valid = 1'b0;
        resetn   = 1'b0;
        #1;
        chk("halt_rst_clear", halted, 0);
        cyc();
        resetn = 1'b1;
        #1;

        // Asynchronous reset in the middle of MEM
        in_valid = 1'b1;
        instr    = 4'd0;
        cyc();
        in_valid = 1'b0;
        #1;
        chk("arst_mem_read_before", mem_read, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_mem_read", mem_read, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_halted", halted, 0);
        chk("arst_alu1", alu1, 1);
        chk("arst_alu_op", alu_op, 0);
        cyc();
        resetn = 1'b1;
        #1;

        // Ack arriving on the last allowed MEM cycle wins over the timeout
        in_valid = 1'b1;
        instr    = 4'd2;
        cyc();
        in_valid = 1'b0;
        repeat (MEM_TIMEOUT - 1) cyc();
        mem_ack = 1'b1;
        #1;
        chk("edge_mem_write", mem_write, 1);
        cyc();
        mem_ack = 1'b0;
        #1;
        chk("edge_mem_err", mem_err, 0);
        chk("edge_out_valid", out_valid, 1);
        chk("edge_ir3_load", ir3_load, 1);
        cyc();
        #1;
        chk("edge_in_ready", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
